pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 8-bit pipelined processor (IF, ID, EX, DM, WB).
- Keeps a scoreboard of destination registers for instructions in the EX, DM and WB stages.
- Drives the operand-forwarding mux selects, the load-use stall and branch-flush bubbles, and the register-file write enable/address aligned with ans_wb.
- Sits beside the pipeline registers and sequences them; it carries no data.

Parameters:
REG_ADDR_W, 3, register-address width (2**REG_ADDR_W registers; R0 hardwired zero).
FLUSH_CYCLES, 2, number of ID slots squashed per taken branch (1..3).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  REG_ADDR_W  source register A
id_rs2  in  REG_ADDR_W  source register B
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  destination register
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a memory load
ex_branch_taken  in  1  branch in EX resolved taken this cycle
stall_if_id  out  1  hold PC and IF/ID register
bubble_ex  out  1  load a NOP into ID/EX this edge
flush_if_id  out  1  squash IF/ID contents
fwd_a_sel  out  2  operand A source: 00 regfile, 01 EX result, 10 DM result (mux_ans_dm), 11 WB result (ans_wb)
fwd_b_sel  out  2  operand B source, same encoding
wb_we  out  1  register-file write enable, aligned with ans_wb
wb_rd  out  REG_ADDR_W  register-file write address

Behaviour:
Scoreboard state and reset
- Three registered slots, EX, DM and WB, each holding {valid, rd, we, load}, plus flush counter fcnt (0..FLUSH_CYCLES).
- Reset (reset=0, asynchronous): all slots invalid, fcnt=0. All outputs are 0 while in reset and in the cycle after release.
- Reset mid-operation discards all in-flight state immediately; no wb_we pulse may follow.

Slot advance (every edge)
- WB <= DM, DM <= EX.
- EX <= ID fields if id_valid & !stall & !squash; otherwise EX <= invalid.

Forwarding (combinational, per used source rs with rs != 0)
- Priority is youngest first: EX slot (valid & we & rd==rs & !load) -> 01; else DM slot match -> 10; else WB slot match -> 11; else 00.
- Unused sources and rs==0 always select 00.
- The selects name the stage the producer occupies in the current cycle. The datapath samples the selected value at the end of the cycle.

Load-use stall
- stall_if_id = id_valid & !squash & (any used rs != 0 matches EX slot with valid & we & load).
- When stall_if_id=1, bubble_ex=1.
- The stall lasts exactly 1 cycle: on the next cycle the load is in DM and forwarding selects 10.

Branch flush
- squash = ex_branch_taken | (fcnt != 0).
- On ex_branch_taken: fcnt <= FLUSH_CYCLES-1. Otherwise, if fcnt != 0: fcnt <= fcnt-1.
- While squash=1: flush_if_id=1 and bubble_ex=1.
- A taken branch during an active flush restarts the count.
- Flush has priority over stall: while squash=1, stall_if_id=0.

Write-back
- wb_we = WB.valid & WB.we & (WB.rd != 0); wb_rd = WB.rd. Both are combinational from the WB slot.
- An instruction in ID at cycle t (not stalled or squashed) is in EX at t+1, DM at t+2, and has wb_we=1 at t+3.

Boundaries
- A register that is both written in WB and read in ID selects 11, so it does not depend on regfile write-through.
- Both sources matching different slots resolve independently.

Decomposition:
Shared package pipe_pkg holds:
- REG_ADDR_W
- fwd-select encodings FWD_RF/FWD_EX/FWD_DM/FWD_WB
- slot record typedef {valid, rd, we, load}

One sub-module is natural: fwd_select (combinational source-priority resolver), instantiated twice, for operands A and B.

Test Plan:
1. Reset held low 3 cycles, then released with id_valid=0 -> all outputs 0, wb_we never pulses.
2. Issue ADD R1 (cycle 0), then SUB with rs1=R1 (cycle 1) -> fwd_a_sel=01 in cycle 1; wb_we=1, wb_rd=1 in cycle 3.
3. LOAD R2 (cycle 0), then ADD with rs2=R2 (cycle 1) -> stall_if_id=1 and bubble_ex=1 in cycle 1 only; cycle 2 shows fwd_b_sel=10 and no stall.
4. Producers of R3 at distances 1, 2 and 3 ahead of a consumer, in separate runs -> fwd selects 01, 10 and 11 respectively; rs=R0 always gives 00 and never stalls.
5. ex_branch_taken pulsed in cycle 5 with FLUSH_CYCLES=2 -> flush_if_id=1 and bubble_ex=1 in cycles 5-6; the squashed instructions never raise wb_we.
6. ex_branch_taken in cycle 5 while a load-use hazard is present, then reset asserted in cycle 6 -> no stall in cycle 5; all outputs 0 from cycle 6 on, and no wb_we afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Slot records describe one in-flight instruction's register-file footprint.
package pipe_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_DM = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic slot_hit(input slot_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid && s.we && (s.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source resolver: picks the youngest in-flight producer of one source register
// and flags a pending load in EX that the operand would have to wait for.
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_used,
    input  slot_t                 i_ex,
    input  slot_t                 i_dm,
    input  slot_t                 i_wb,
    output logic [1:0]            o_sel,
    output logic                  o_load_hit
);

    logic w_active;

    // R0 is hardwired zero, so it never has a producer worth forwarding.
    assign w_active = i_used && (i_rs != '0);

    always_comb begin
        o_sel = FWD_RF;
        if (w_active) begin
            if (slot_hit(i_ex, i_rs) && !i_ex.load) begin
                o_sel = FWD_EX;
            end else if (slot_hit(i_dm, i_rs)) begin
                o_sel = FWD_DM;
            end else if (slot_hit(i_wb, i_rs)) begin
                o_sel = FWD_WB;
            end
        end
    end

    assign o_load_hit = w_active && slot_hit(i_ex, i_rs) && i_ex.load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: destination scoreboard, forwarding selects,
// load-use stall, branch flush bubbles and the aligned register-file write strobe.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = pipe_pkg::REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd
);
    import pipe_pkg::*;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    slot_t      r_ex;
    slot_t      r_dm;
    slot_t      r_wb;
    logic [1:0] r_fcnt;
    logic       r_run;

    logic                  w_branch;
    logic                  w_squash;
    logic                  w_stall;
    slot_t                 w_ex_next;
    logic [REG_ADDR_W-1:0] w_rs   [2];
    logic                  w_used [2];
    logic [1:0]            w_sel  [2];
    logic                  w_hit  [2];

    assign w_rs[0]   = id_rs1;
    assign w_rs[1]   = id_rs2;
    assign w_used[0] = id_rs1_used;
    assign w_used[1] = id_rs2_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd (
                .i_rs       (w_rs[gi]),
                .i_used     (w_used[gi]),
                .i_ex       (r_ex),
                .i_dm       (r_dm),
                .i_wb       (r_wb),
                .o_sel      (w_sel[gi]),
                .o_load_hit (w_hit[gi])
            );
        end
    endgenerate

    // r_run stays low through reset and the first cycle after release, keeping every output quiet.
    assign w_branch = r_run && ex_branch_taken;
    assign w_squash = w_branch || (r_fcnt != 2'd0);
    assign w_stall  = r_run && id_valid && !w_squash && (w_hit[0] || w_hit[1]);

    always_comb begin
        w_ex_next = SLOT_EMPTY;
        if (r_run && id_valid && !w_stall && !w_squash) begin
            w_ex_next.valid = 1'b1;
            w_ex_next.rd    = id_rd;
            w_ex_next.we    = id_rd_we;
            w_ex_next.load  = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex   <= SLOT_EMPTY;
            r_dm   <= SLOT_EMPTY;
            r_wb   <= SLOT_EMPTY;
            r_fcnt <= 2'd0;
            r_run  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_wb  <= r_dm;
            r_dm  <= r_ex;
            r_ex  <= w_ex_next;
            // A taken branch restarts the squash window even if one is already running.
            if (w_branch) begin
                r_fcnt <= FLUSH_INIT;
            end else if (r_fcnt != 2'd0) begin
                r_fcnt <= r_fcnt - 2'd1;
            end
        end
    end

    assign stall_if_id = w_stall;
    assign bubble_ex   = w_stall || w_squash;
    assign flush_if_id = w_squash;
    assign fwd_a_sel   = w_sel[0];
    assign fwd_b_sel   = w_sel[1];
    assign wb_we       = r_wb.valid && r_wb.we && (r_wb.rd != '0);
    assign wb_rd       = r_wb.rd;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle directed expectations plus a
// write-back scoreboard filled when an instruction is accepted from ID.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_rd_we = 1'b0, id_is_load = 1'b0, ex_branch_taken = 1'b0;
    logic       stall_if_id, bubble_ex, flush_if_id, wb_we;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [2:0] wb_rd;

    typedef struct {
        int         due;
        logic [2:0] rd;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_rd_we        (id_rd_we),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs1, input logic u1,
                          input logic [2:0] rs2, input logic u2,
                          input logic [2:0] rd, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_rd_we    = we;
        id_is_load  = ld;
    endtask

    // One clock cycle: record accepted writer, sample mid-cycle, compare, advance.
    task automatic step(input string tag, input logic e_stall, input logic e_bubble,
                        input logic e_flush, input logic [1:0] e_a, input logic [1:0] e_b,
                        input logic zero_rd);
        logic       exp_we;
        logic [2:0] exp_rd;
        if (reset && id_valid && id_rd_we && id_rd != 3'd0 && !e_stall && !e_flush)
            wb_q.push_back('{cyc + 3, id_rd});
        @(negedge clk);
        check_val({tag, ".stall"},  {7'd0, stall_if_id}, {7'd0, e_stall});
        check_val({tag, ".bubble"}, {7'd0, bubble_ex},   {7'd0, e_bubble});
        check_val({tag, ".flush"},  {7'd0, flush_if_id}, {7'd0, e_flush});
        check_val({tag, ".fwd_a"},  {6'd0, fwd_a_sel},   {6'd0, e_a});
        check_val({tag, ".fwd_b"},  {6'd0, fwd_b_sel},   {6'd0, e_b});
        exp_we = (wb_q.size() > 0) && (wb_q[0].due == cyc);
        exp_rd = exp_we ? wb_q[0].rd : 3'd0;
        if (exp_we) void'(wb_q.pop_front());
        check_val({tag, ".wb_we"}, {7'd0, wb_we}, {7'd0, exp_we});
        if (exp_we || zero_rd)
            check_val({tag, ".wb_rd"}, {5'd0, wb_rd}, {5'd0, exp_rd});
        $display("[%0d] %s stall=%b bubble=%b flush=%b fa=%0d fb=%0d wb_we=%b wb_rd=%0d",
                 cyc, tag, stall_if_id, bubble_ex, flush_if_id, fwd_a_sel, fwd_b_sel, wb_we, wb_rd);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        set_id(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0);
        ex_branch_taken = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) step("idle", 0, 0, 0, FWD_RF, FWD_RF, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held for three cycles; a branch strobe during reset must not leak out.
        ex_branch_taken = 1'b1;
        step("rst0", 0, 0, 0, FWD_RF, FWD_RF, 1);
        ex_branch_taken = 1'b0;
        step("rst1", 0, 0, 0, FWD_RF, FWD_RF, 1);
        step("rst2", 0, 0, 0, FWD_RF, FWD_RF, 1);
        reset = 1'b1;
        step("release", 0, 0, 0, FWD_RF, FWD_RF, 1);
        drain();

        // EX forwarding from the immediately preceding ALU op.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0);
        step("add_r1", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd1, 1, 3'd4, 1, 3'd5, 1, 0);
        step("sub_r1", 0, 0, 0, FWD_EX, FWD_RF, 0);
        drain();

        // Load-use: one stall cycle, then DM forwarding.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1);
        step("load_r2", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 1, 3'd2, 1, 3'd3, 1, 0);
        step("lu_stall", 1, 1, 0, FWD_RF, FWD_RF, 0);
        step("lu_fwd", 0, 0, 0, FWD_RF, FWD_DM, 0);
        drain();

        // Distance 1, unused rs2 naming the same register.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("prod_d1", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd3, 1, 3'd3, 0, 3'd6, 1, 0);
        step("cons_d1", 0, 0, 0, FWD_EX, FWD_RF, 0);
        drain();

        // Distance 2.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("prod_d2", 0, 0, 0, FWD_RF, FWD_RF, 0);
        idle();
        step("gap_d2", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd3, 1, 3'd0, 1, 3'd6, 1, 0);
        step("cons_d2", 0, 0, 0, FWD_DM, FWD_RF, 0);
        drain();

        // Distance 3: both sources read the register being written back.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("prod_d3", 0, 0, 0, FWD_RF, FWD_RF, 0);
        idle();
        step("gap_d3a", 0, 0, 0, FWD_RF, FWD_RF, 0);
        step("gap_d3b", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd3, 1, 3'd3, 1, 3'd6, 1, 0);
        step("cons_d3", 0, 0, 0, FWD_WB, FWD_WB, 0);
        drain();

        // A load targeting R0 never stalls nor forwards.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1);
        step("load_r0", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 1, 3'd0, 1, 3'd4, 1, 0);
        step("cons_r0", 0, 0, 0, FWD_RF, FWD_RF, 0);
        drain();

        // Independent sources from different slots.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("prod_r3", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0);
        step("prod_r4", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd3, 1, 3'd4, 1, 3'd6, 1, 0);
        step("cons_mix", 0, 0, 0, FWD_DM, FWD_EX, 0);
        drain();

        // Youngest producer wins.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("old_r3", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0);
        step("prod_r5", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
        step("new_r3", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd3, 1, 3'd5, 1, 3'd7, 1, 0);
        step("cons_young", 0, 0, 0, FWD_EX, FWD_DM, 0);
        drain();

        // Taken branch squashes two ID slots.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0);
        ex_branch_taken = 1'b1;
        step("br", 0, 1, 1, FWD_RF, FWD_RF, 0);
        ex_branch_taken = 1'b0;
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0);
        step("br_sq1", 0, 1, 1, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0);
        step("br_done", 0, 0, 0, FWD_RF, FWD_RF, 0);
        drain();

        // Back-to-back taken branches restart the window.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0);
        ex_branch_taken = 1'b1;
        step("br2a", 0, 1, 1, FWD_RF, FWD_RF, 0);
        step("br2b", 0, 1, 1, FWD_RF, FWD_RF, 0);
        ex_branch_taken = 1'b0;
        step("br2_tail", 0, 1, 1, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0);
        step("br2_done", 0, 0, 0, FWD_RF, FWD_RF, 0);
        drain();

        // Branch overrides a load-use hazard, then reset lands mid-flight.
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1);
        step("load_r2b", 0, 0, 0, FWD_RF, FWD_RF, 0);
        set_id(1, 3'd2, 1, 3'd0, 0, 3'd3, 1, 0);
        ex_branch_taken = 1'b1;
        step("br_over_lu", 0, 1, 1, FWD_RF, FWD_RF, 0);
        reset = 1'b0;
        wb_q.delete();
        step("rst_mid0", 0, 0, 0, FWD_RF, FWD_RF, 1);
        step("rst_mid1", 0, 0, 0, FWD_RF, FWD_RF, 1);
        idle();
        reset = 1'b1;
        step("rel_mid", 0, 0, 0, FWD_RF, FWD_RF, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
